// File: rtl/hdlverifier_jtag_cmd_shifter.sv
// rtl/hdlverifier_jtag_cmd_shifter.sv - JTAG user-DR scan frame to register access initiator (TCK domain)
module hdlverifier_jtag_cmd_shifter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  tck,
    input  logic                  reset,
    input  logic                  sel,
    input  logic                  capture,
    input  logic                  shift,
    input  logic                  update,
    input  logic                  tdi,
    output logic                  tdo,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  write,
    input  logic [DATA_WIDTH-1:0] rdata
);

    localparam int FW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(FW + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FW);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

    logic [FW-1:0]         shreg, shreg_nxt;
    logic [CW-1:0]         bitcnt, bitcnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic                  write_nxt;
    logic                  err, err_nxt;

    assign tdo = shreg[0];

    // Strobe priority is capture > update > shift; all ignored unless sel.
    always_comb begin
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        addr_nxt   = addr;
        wdata_nxt  = wdata;
        write_nxt  = 1'b0;
        err_nxt    = err;
        if (sel && capture) begin
            shreg_nxt  = {rdata, addr, err};
            bitcnt_nxt = '0;
            err_nxt    = 1'b0;
        end else if (sel && update) begin
            if (bitcnt == CNT_FULL) begin
                // Gating on write keeps a held update from producing back-to-back strobes.
                if (!write) begin
                    addr_nxt = shreg[ADDR_WIDTH:1];
                    if (shreg[0]) begin
                        wdata_nxt = shreg[FW-1:ADDR_WIDTH+1];
                        write_nxt = 1'b1;
                    end
                end
            end else begin
                err_nxt = 1'b1;
            end
        end else if (sel && shift) begin
            shreg_nxt = {tdi, shreg[FW-1:1]};
            if (bitcnt != CNT_SAT) begin
                bitcnt_nxt = bitcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            shreg  <= '0;
            bitcnt <= '0;
            addr   <= '0;
            wdata  <= '0;
            write  <= 1'b0;
            err    <= 1'b0;
        end else begin
            shreg  <= shreg_nxt;
            bitcnt <= bitcnt_nxt;
            addr   <= addr_nxt;
            wdata  <= wdata_nxt;
            write  <= write_nxt;
            err    <= err_nxt;
        end
    end

endmodule
